// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the arbiter state encoding, read-return port tags and default widths.
package dmem_arb_pkg;

    typedef enum logic {
        OPEN  = 1'b0,
        HLOCK = 1'b1
    } arb_state_t;

    localparam logic TAG_CPU  = 1'b0;
    localparam logic TAG_HOST = 1'b1;

    localparam int unsigned DEF_AW         = 8;
    localparam int unsigned DEF_DW         = 16;
    localparam int unsigned DEF_LOCK_MAX   = 4;
    localparam int unsigned DEF_STARVE_MAX = 8;

endpackage

// File: rtl/dmem_arb_rdret.sv
// Read-return steering: registers the tag/valid of a granted read and routes
// the memory's synchronous read data to the port that issued it.
module dmem_arb_rdret
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rd_fire,
    input  logic          rd_tag,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata
);

    logic          vld_q;
    logic          tag_q;
    logic [DW-1:0] cpu_hold_q;
    logic [DW-1:0] host_hold_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q       <= 1'b0;
            tag_q       <= TAG_CPU;
            cpu_hold_q  <= '0;
            host_hold_q <= '0;
        end else begin
            vld_q       <= rd_fire;
            tag_q       <= rd_tag;
            cpu_hold_q  <= cpu_rdata;
            host_hold_q <= host_rdata;
        end
    end

    // The non-returning port keeps presenting the data it last received.
    assign cpu_rvalid  = vld_q && (tag_q == TAG_CPU);
    assign host_rvalid = vld_q && (tag_q == TAG_HOST);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_hold_q;
    assign host_rdata  = host_rvalid ? mem_rdata : host_hold_q;

endmodule

// File: rtl/dmem_arbiter.sv
// CPU / host-loader arbiter for the single data-memory port.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned LOCK_MAX   = DEF_LOCK_MAX,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned LCW = $clog2(LOCK_MAX + 1);

    arb_state_t     state, state_nxt;
    logic [LCW-1:0] lock_cnt, lock_cnt_nxt, lock_inc;
    logic           host_first;
    logic           any_gnt;
    logic [AW-1:0]  sel_addr, addr_q;
    logic [DW-1:0]  sel_wdata, wdata_q;
    logic           sel_we;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= OPEN;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // lock_cnt counts host cycles already granted in this lock, the entry grant included.
    assign lock_inc = lock_cnt + LCW'(1);

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            OPEN: begin
                if (host_gnt && host_lock && (LOCK_MAX > 1)) begin
                    state_nxt    = HLOCK;
                    lock_cnt_nxt = LCW'(1);
                end
            end
            HLOCK: begin
                if (!host_req || !host_lock || (lock_inc == LCW'(LOCK_MAX))) begin
                    state_nxt    = OPEN;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_inc;
                end
            end
            default: begin
                state_nxt    = OPEN;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        case (state)
            OPEN: begin
                if (cpu_req && !(host_req && host_first)) begin
                    cpu_gnt = 1'b1;
                end else if (host_req) begin
                    host_gnt = 1'b1;
                end
            end
            HLOCK: host_gnt = host_req;
            default: ;
        endcase
    end

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (host_gnt) begin
            starve_cnt <= '0;
        end else if ((state == OPEN) && host_req && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign host_first = (starve_cnt == 4'(STARVE_MAX));
`else
    assign host_first = 1'b0;
`endif

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign any_gnt   = cpu_gnt | host_gnt;
    assign sel_addr  = host_gnt ? host_addr  : cpu_addr;
    assign sel_wdata = host_gnt ? host_wdata : cpu_wdata;
    assign sel_we    = host_gnt ? host_we    : cpu_we;

    // Idle cycles replay the last granted address/data so the macro pins stay quiet.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (any_gnt) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    assign mem_addr  = any_gnt ? sel_addr  : addr_q;
    assign mem_wdata = any_gnt ? sel_wdata : wdata_q;
    assign mem_we    = any_gnt & sel_we;

    dmem_arb_rdret #(
        .DW(DW)
    ) u_rdret (
        .clock       (clock),
        .reset       (reset),
        .rd_fire     (any_gnt & ~sel_we),
        .rd_tag      (host_gnt ? TAG_HOST : TAG_CPU),
        .mem_rdata   (mem_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata)
    );

endmodule
